// File: rtl/fir_coeff_seq.sv
// Coefficient sequencer: on each accepted sample, sweeps the coefficient ROM over
// taps 0..TAPS-1 and streams {coeff, sample, tap, first, last} beats through a
// 4-deep FIFO. The FIFO hides the registered ROM read latency under backpressure.
module fir_coeff_seq #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned TAPS         = 32,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input  logic                    clk_i,
   input  logic                    arstn_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [SAMPLE_WIDTH-1:0] s_data_i,
   output logic [ADDR_WIDTH-1:0]   rom_addr_o,
   input  logic [DATA_WIDTH-1:0]   rom_data_i,
   output logic                    m_valid_o,
   input  logic                    m_ready_i,
   output logic [DATA_WIDTH-1:0]   m_coeff_o,
   output logic [SAMPLE_WIDTH-1:0] m_sample_o,
   output logic [ADDR_WIDTH-1:0]   m_tap_o,
   output logic                    m_first_o,
   output logic                    m_last_o,
   output logic                    busy_o
);

   // Issue counter is one bit wider so a full 2**ADDR_WIDTH sweep never wraps.
   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LastTap = CW'(TAPS - 1);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(TAPS - 1);

   if (TAPS < 1 || TAPS > (2 ** ADDR_WIDTH)) begin : g_bad_taps
      $error("fir_coeff_seq: TAPS must be in 1..2**ADDR_WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           next_q, next_d;
   logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic                    issue_q;
   logic                    rd_v_q;
   logic [ADDR_WIDTH-1:0]   rd_tap_q;
   logic [1:0]              inflight_q, inflight_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

   logic [DATA_WIDTH-1:0]   coeff_mem_q [4];
   logic [ADDR_WIDTH-1:0]   tap_mem_q   [4];
   logic                    first_mem_q [4];
   logic                    last_mem_q  [4];
   logic [1:0]              wr_ptr_q, wr_ptr_d;
   logic [1:0]              rd_ptr_q, rd_ptr_d;
   logic [2:0]              count_q, count_d;

   logic                    s_hs;
   logic                    push;
   logic                    pop;
   logic [3:0]              occ;
   logic                    credit_ok;
   logic                    issue_run;
   logic                    issue;

   // Handshakes and the credit rule: room must exist for every read already in flight.
   always_comb begin
      s_hs      = s_valid_i && (state_q == StIdle);
      push      = rd_v_q;
      pop       = (count_q != 3'd0) && m_ready_i;
      occ       = 4'(count_q) + 4'(inflight_q) + 4'd1 - 4'(pop);
      credit_ok = (occ <= 4'd4);
      issue_run = (state_q == StRun) && credit_ok;
      issue     = s_hs || issue_run;
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; the handshake itself issues tap 0.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (s_hs) state_d = (TAPS == 1) ? StDrain : StRun;
         StRun:   if (issue_run && (next_q == LastTap)) state_d = StDrain;
         StDrain: if (pop && last_mem_q[rd_ptr_q]) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      s_ready_o = (state_q == StIdle);
      busy_o    = (state_q != StIdle);
   end

   // Datapath next state: address issue, in-flight tracking, FIFO pointers.
   always_comb begin
      rom_addr_d = rom_addr_q;
      next_d     = next_q;
      sample_d   = sample_q;
      if (s_hs) begin
         rom_addr_d = '0;
         next_d     = CW'(1);
         sample_d   = s_data_i;
      end else if (issue_run) begin
         rom_addr_d = next_q[ADDR_WIDTH-1:0];
         next_d     = next_q + CW'(1);
      end
      inflight_d = inflight_q + {1'b0, issue} - {1'b0, push};
      count_d    = count_q + {2'b00, push} - {2'b00, pop};
      wr_ptr_d   = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
   end

   // Datapath registers; rd_v_q marks the cycle in which rom_data_i is valid.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         next_q     <= '0;
         rom_addr_q <= '0;
         issue_q    <= 1'b0;
         rd_v_q     <= 1'b0;
         rd_tap_q   <= '0;
         inflight_q <= '0;
         sample_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         next_q     <= next_d;
         rom_addr_q <= rom_addr_d;
         issue_q    <= issue;
         rd_v_q     <= issue_q;
         rd_tap_q   <= rom_addr_q;
         inflight_q <= inflight_d;
         sample_q   <= sample_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; cleared on reset so the head payload reads zero.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int k = 0; k < 4; k++) begin
            coeff_mem_q[k] <= '0;
            tap_mem_q[k]   <= '0;
            first_mem_q[k] <= 1'b0;
            last_mem_q[k]  <= 1'b0;
         end
      end else if (push) begin
         coeff_mem_q[wr_ptr_q] <= rom_data_i;
         tap_mem_q[wr_ptr_q]   <= rd_tap_q;
         first_mem_q[wr_ptr_q] <= (rd_tap_q == '0);
         last_mem_q[wr_ptr_q]  <= (rd_tap_q == LastAddr);
      end
   end

   // Stream outputs come straight from the FIFO head.
   always_comb begin
      rom_addr_o = rom_addr_q;
      m_valid_o  = (count_q != 3'd0);
      m_coeff_o  = coeff_mem_q[rd_ptr_q];
      m_tap_o    = tap_mem_q[rd_ptr_q];
      m_first_o  = first_mem_q[rd_ptr_q];
      m_last_o   = last_mem_q[rd_ptr_q];
      m_sample_o = sample_q;
   end

endmodule

// File: tb/tb_fir_coeff_seq.sv
// Bench for fir_coeff_seq: four instances (TAPS 4/32/1, and 8 taps on a 3-bit
// address) each checked every cycle against a queue-of-beats sweep model.
module tb_fir_coeff_seq;

   typedef struct {
      logic [15:0] coeff;
      logic [15:0] sample;
      int          tap;
      bit          first;
      bit          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   logic        s_valid [4];
   logic [15:0] s_data  [4];
   logic        m_ready [4];
   int          rdy_pct [4];
   bit          model_idle [4];
   int          acc_cnt [4];
   int          acc_cyc [4];
   int          fv_cyc  [4];
   int          last_pop_cyc [4];
   logic [15:0] popped [4][$];

   logic [15:0] basic_exp [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [15:0] rom_val(input int inst, input int a);
      case (inst)
         0:       rom_val = 16'((a + 1) * 32'h11);
         2:       rom_val = 16'h7FFF;
         default: rom_val = 16'(a * 32'h1357 + 32'hA5A5 + inst * 7);
      endcase
   endfunction

   task automatic chk(input int inst, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL u%0d %s: got 0x%0h expected 0x%0h", inst, nm, act, exp);
      end
   endtask

   for (genvar I = 0; I < 4; I++) begin : g
      localparam int AW = (I == 3) ? 3 : 5;
      localparam int TP = (I == 0) ? 4 : (I == 1) ? 32 : (I == 2) ? 1 : 8;

      logic          s_ready, m_valid, m_first, m_last, busy;
      logic [AW-1:0] rom_addr, m_tap;
      logic [15:0]   rom_data = '0;
      logic [15:0]   m_coeff, m_sample;
      beat_t         exp_q [$];
      bit            idle = 1'b1;
      bit            fv_seen = 1'b1;
      logic [15:0]   samp = '0;

      fir_coeff_seq #(
         .DATA_WIDTH  (16),
         .ADDR_WIDTH  (AW),
         .TAPS        (TP),
         .SAMPLE_WIDTH(16)
      ) u_dut (
         .clk_i     (clk),
         .arstn_i   (rst_n),
         .s_valid_i (s_valid[I]),
         .s_ready_o (s_ready),
         .s_data_i  (s_data[I]),
         .rom_addr_o(rom_addr),
         .rom_data_i(rom_data),
         .m_valid_o (m_valid),
         .m_ready_i (m_ready[I]),
         .m_coeff_o (m_coeff),
         .m_sample_o(m_sample),
         .m_tap_o   (m_tap),
         .m_first_o (m_first),
         .m_last_o  (m_last),
         .busy_o    (busy)
      );

      // Synchronous ROM with one-cycle registered read.
      always @(posedge clk) rom_data <= rom_val(I, int'(rom_addr));

      // Downstream ready, random at the configured percentage.
      always @(posedge clk) begin
         #1;
         m_ready[I] = ($urandom_range(99) < rdy_pct[I]);
      end

      // Compare against the model, then apply the handshakes due at the next edge.
      always @(negedge clk) begin
         beat_t b;
         bit    accept;
         if (!rst_n) begin
            exp_q.delete();
            idle = 1'b1;
            samp = '0;
            chk(I, "rst m_valid", 32'(m_valid), 0);
            chk(I, "rst s_ready", 32'(s_ready), 1);
            chk(I, "rst busy", 32'(busy), 0);
            chk(I, "rst rom_addr", 32'(rom_addr), 0);
            chk(I, "rst m_sample", 32'(m_sample), 0);
            chk(I, "rst m_coeff", 32'(m_coeff), 0);
            chk(I, "rst m_tap", 32'(m_tap), 0);
            chk(I, "rst m_first", 32'(m_first), 0);
            chk(I, "rst m_last", 32'(m_last), 0);
         end else begin
            chk(I, "s_ready", 32'(s_ready), 32'(idle));
            chk(I, "busy", 32'(busy), 32'(!idle));
            chk(I, "m_sample", 32'(m_sample), 32'(samp));
            if (exp_q.size() == 0) begin
               chk(I, "m_valid idle", 32'(m_valid), 0);
            end else if (m_valid) begin
               if (!fv_seen) begin
                  fv_seen = 1'b1;
                  fv_cyc[I] = cyc;
               end
               chk(I, "m_coeff", 32'(m_coeff), 32'(exp_q[0].coeff));
               chk(I, "m_tap", 32'(m_tap), 32'(exp_q[0].tap));
               chk(I, "m_first", 32'(m_first), 32'(exp_q[0].first));
               chk(I, "m_last", 32'(m_last), 32'(exp_q[0].last));
            end
            accept = s_valid[I] && idle;
            if (m_valid && m_ready[I] && exp_q.size() > 0) begin
               b = exp_q.pop_front();
               popped[I].push_back(b.coeff);
               last_pop_cyc[I] = cyc;
               if (b.last) idle = 1'b1;
            end
            if (accept) begin
               for (int t = 0; t < TP; t++) begin
                  b.coeff  = rom_val(I, t);
                  b.sample = s_data[I];
                  b.tap    = t;
                  b.first  = (t == 0);
                  b.last   = (t == TP - 1);
                  exp_q.push_back(b);
               end
               idle = 1'b0;
               samp = s_data[I];
               acc_cnt[I]++;
               acc_cyc[I] = cyc;
               fv_seen = 1'b0;
            end
         end
         model_idle[I] = idle;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sample(input int i, input logic [15:0] d);
      tick();
      s_valid[i] = 1'b1;
      s_data[i]  = d;
      tick();
      s_valid[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int budget);
      int n = 0;
      while (!model_idle[i] && n < budget) begin
         tick();
         n++;
      end
      chk(i, "sweep completes in budget", 32'(model_idle[i]), 1);
   endtask

   task automatic sweep(input int i, input logic [15:0] d, input int pct, input int budget);
      int a0;
      a0 = acc_cnt[i];
      rdy_pct[i] = pct;
      popped[i].delete();
      start_sample(i, d);
      chk(i, "sample accepted", 32'(acc_cnt[i] - a0), 1);
      wait_idle(i, budget);
      tick();
   endtask

   initial begin
      int a0;
      int n;
      for (int i = 0; i < 4; i++) begin
         s_valid[i] = 1'b0;
         s_data[i]  = '0;
         m_ready[i] = 1'b0;
         rdy_pct[i] = 100;
         model_idle[i] = 1'b1;
         acc_cnt[i] = 0;
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic sweep, TAPS=4.
      sweep(0, 16'h1234, 100, 50);
      chk(0, "first beat latency", 32'(fv_cyc[0] - acc_cyc[0]), 3);
      chk(0, "last beat cycle", 32'(last_pop_cyc[0] - acc_cyc[0]), 6);
      chk(0, "beat count", 32'(popped[0].size()), 4);
      for (int k = 0; k < 4; k++)
         chk(0, "basic coeff", (popped[0].size() > k) ? 32'(popped[0][k]) : 32'hDEAD,
             32'(basic_exp[k]));
      chk(0, "held sample", 32'(g[0].m_sample), 32'h1234);

      // Minimum taps.
      sweep(2, 16'h0BEE, 100, 50);
      chk(2, "single beat", 32'(popped[2].size()), 1);
      chk(2, "single coeff", (popped[2].size() > 0) ? 32'(popped[2][0]) : 32'hDEAD, 32'h7FFF);
      chk(2, "single latency", 32'(fv_cyc[2] - acc_cyc[2]), 3);

      // Full address range on a 3-bit ROM address.
      sweep(3, 16'hC0DE, 100, 60);
      chk(3, "full-range beats", 32'(popped[3].size()), 8);
      chk(3, "last addr held", 32'(g[3].rom_addr), 7);
      chk(3, "full-range throughput", 32'(last_pop_cyc[3] - acc_cyc[3]), 10);

      // Backpressure at 30% ready.
      sweep(1, 16'(32'($urandom)), 30, 2000);
      chk(1, "bp beats", 32'(popped[1].size()), 32);
      sweep(1, 16'(32'($urandom)), 30, 2000);
      chk(1, "bp beats 2", 32'(popped[1].size()), 32);

      // Back-to-back: valid held through A's sweep; B accepted only afterwards.
      rdy_pct[1] = 70;
      popped[1].delete();
      a0 = acc_cnt[1];
      tick();
      s_valid[1] = 1'b1;
      s_data[1]  = 16'hAAAA;
      n = 0;
      while (acc_cnt[1] == a0 && n < 20) begin tick(); n++; end
      s_data[1] = 16'hBBBB;
      n = 0;
      while (acc_cnt[1] == a0 + 1 && n < 500) begin tick(); n++; end
      chk(1, "B accepted after A", 32'(acc_cnt[1] - a0), 2);
      chk(1, "A fully delivered first", 32'(popped[1].size()), 32);
      for (int k = 0; k < 20; k++) begin
         s_valid[1] = 1'($urandom_range(1));
         s_data[1]  = 16'(32'($urandom));
         tick();
      end
      s_valid[1] = 1'b0;
      wait_idle(1, 1000);
      chk(1, "mid-sweep pulses ignored", 32'(acc_cnt[1] - a0), 2);
      chk(1, "A+B beats", 32'(popped[1].size()), 64);
      tick();

      // Reset mid-sweep at tap 10.
      rdy_pct[1] = 100;
      popped[1].delete();
      start_sample(1, 16'h5A5A);
      n = 0;
      while (popped[1].size() < 10 && n < 100) begin tick(); n++; end
      chk(1, "reached tap 10", 32'(popped[1].size()), 10);
      rst_n = 1'b0;
      #1;
      chk(1, "arst m_valid", 32'(g[1].m_valid), 0);
      chk(1, "arst busy", 32'(g[1].busy), 0);
      chk(1, "arst s_ready", 32'(g[1].s_ready), 1);
      chk(1, "arst rom_addr", 32'(g[1].rom_addr), 0);
      chk(1, "arst m_tap", 32'(g[1].m_tap), 0);
      chk(1, "arst m_sample", 32'(g[1].m_sample), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      sweep(1, 16'h1357, 100, 100);
      chk(1, "post-reset beats", 32'(popped[1].size()), 32);
      chk(1, "post-reset first coeff", (popped[1].size() > 0) ? 32'(popped[1][0]) : 32'hDEAD,
          32'(rom_val(1, 0)));
      chk(1, "post-reset throughput", 32'(last_pop_cyc[1] - acc_cyc[1]), 34);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
